async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data_in/data_out.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 4, log2(DEPTH).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 write_clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 read_clk  input  1  kept for port compatibility only; integrators SHALL tie it to write_clk; no logic SHALL use it.
REQ-008 write_en  input  1  write request.
REQ-009 read_en  input  1  read request.
REQ-010 data_in  input  DATA_WIDTH  write data, sampled on a write-accept edge.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 empty  output  1  high when count == 0.
REQ-014 valid  output  1  one-cycle pulse; data_out holds newly read data.
REQ-015 over_flow  output  1  one-cycle pulse; a write was rejected.
REQ-016 under_flow  output  1  one-cycle pulse; a read was rejected.

Function
REQ-017 The state SHALL consist of storage[DEPTH], wr_ptr and rd_ptr (ADDR_WIDTH bits each), and count (ADDR_WIDTH+1 bits, range 0..DEPTH).
REQ-018 full and empty SHALL be combinational decodes of count, with no extra latency.
REQ-019 Write accept = write_en && !full, using pre-edge flags: storage[wr_ptr] <= data_in and wr_ptr increments.
REQ-020 Read accept = read_en && !empty, using pre-edge flags: data_out <= storage[rd_ptr] and rd_ptr increments.
REQ-021 Read latency: data appears on data_out at the edge that accepts the read; valid is high for exactly that following cycle.
REQ-022 When no read is accepted, data_out SHALL hold its last value and valid SHALL be 0.
REQ-023 Pointers SHALL wrap modulo DEPTH, from DEPTH-1 to 0, without any bubble.
REQ-024 count update per edge:
- +1 on write only
- -1 on read only
- unchanged when both or neither are accepted.
REQ-025 Simultaneous write and read when neither full nor empty: both accepted and count unchanged.
REQ-026 Simultaneous write and read when full: read accepted, write rejected, over_flow pulses, count becomes DEPTH-1.
REQ-027 Simultaneous write and read when empty: write accepted, read rejected, under_flow pulses, count becomes 1, valid stays 0.
REQ-028 over_flow SHALL be registered: high for one cycle after an edge where write_en && full; else 0.
REQ-029 under_flow SHALL be registered: high for one cycle after an edge where read_en && empty; else 0.
REQ-030 A rejected operation SHALL change neither pointers, storage, count nor data_out.
REQ-031 Data SHALL leave in strict FIFO order, with no loss or duplication of accepted entries.

Reset
REQ-032 While reset == 0, the block SHALL immediately clear:
- wr_ptr, rd_ptr and count to 0
- data_out to 0
- valid, over_flow and under_flow to 0
- resulting in empty=1 and full=0.
REQ-033 Storage contents need not be cleared.
REQ-034 Reset asserted mid-operation SHALL discard all contents; the first post-reset read returns the first post-reset write.
REQ-035 Operations SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-036 After reset, write 0xA1,0xB2,0xC3 on consecutive cycles, then read 3 cycles -> data_out 0xA1,0xB2,0xC3, each with a one-cycle valid pulse, then empty=1.
REQ-037 Write DEPTH values 0x00..0x0F -> full=1 after the 16th edge; one further write of 0xFF -> over_flow pulses once, and a later drain returns 0x00..0x0F (never 0xFF).
REQ-038 Hold read_en=1 while empty -> under_flow high each cycle, valid=0, data_out unchanged.
REQ-039 Run 50 random writes with random-paced reads, over at least 3 pointer wraps, checked against a reference queue -> every read matches, count never exceeds 16, and no spurious valid/over_flow/under_flow.
REQ-040 While full, write and read together -> read returns the oldest entry, the write is dropped with over_flow, and full deasserts (count 15).
REQ-041 Assert reset with 5 entries stored -> empty=1, full=0 and data_out=0 with no clock edge; then write 0x3C and read -> 0x3C.

Source files
------------

// File: rtl/async_fifo.sv
// Single-clock FIFO keeping the legacy async_fifo name and port list.
// Every register is clocked by write_clk; read_clk remains on the port
// list so existing instantiations still bind, and it is tied to write_clk
// at integration.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  read_clk,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  valid,
  output logic                  over_flow,
  output logic                  under_flow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  // read_clk drives no logic; it feeds only this deliberately idle net
  logic unused_read_clk;
  assign unused_read_clk = read_clk;

  // Flags decode count directly and accepts use the pre-edge flags
  always_comb begin
    full   = (count == DEPTH_CNT);
    empty  = (count == '0);
    wr_acc = write_en && !full;
    rd_acc = read_en && !empty;
  end

  // Storage array; not reset, so stale contents are unreachable after reset
  always_ff @(posedge write_clk) begin
    if (wr_acc) storage[wr_ptr] <= data_in;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**ADDR_WIDTH
  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read data, valid strobe and rejection pulses
  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      valid      <= 1'b0;
      over_flow  <= 1'b0;
      under_flow <= 1'b0;
    end else begin
      if (rd_acc) data_out <= storage[rd_ptr];
      valid      <= rd_acc;
      over_flow  <= write_en && full;
      under_flow <= read_en && empty;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus pushes expected read data into
// a queue, a negedge monitor pops it whenever the DUT raises valid.
module tb_async_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          write_clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, valid, over_flow, under_flow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  always #5 write_clk = ~write_clk;

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .read_clk  (write_clk),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .valid     (valid),
    .over_flow (over_flow),
    .under_flow(under_flow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge as the DUT
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
    logic wa, ra;
    write_en = we;
    read_en  = re;
    data_in  = din;
    @(posedge write_clk);
    wa = we && (m_q.size() != DEPTH);
    ra = re && (m_q.size() != 0);
    exp_ovf   = we && (m_q.size() == DEPTH);
    exp_udf   = re && (m_q.size() == 0);
    exp_valid = ra;
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(din);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_last    = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  // Monitor: compares flags every cycle, pops the scoreboard on valid
  always @(negedge write_clk) begin
    if (reset) begin
      chk("full_flag", 32'(full), 32'(m_q.size() == DEPTH));
      chk("empty_flag", 32'(empty), 32'(m_q.size() == 0));
      chk("valid_flag", 32'(valid), 32'(exp_valid));
      chk("over_flow", 32'(over_flow), 32'(exp_ovf));
      chk("under_flow", 32'(under_flow), 32'(exp_udf));
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(valid), 32'd0);
        end else begin
          m_last = exp_q.pop_front();
          chk("read_data", 32'(data_out), 32'(m_last));
        end
      end else begin
        chk("data_hold", 32'(data_out), 32'(m_last));
      end
    end
  end

  logic [DW-1:0] abc [3];

  initial begin
    abc[0] = 8'hA1; abc[1] = 8'hB2; abc[2] = 8'hC3;

    // Reset state
    #3;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(over_flow), 32'd0);
    chk("rst_udf", 32'(under_flow), 32'd0);
    @(negedge write_clk); #2 reset = 1'b1;

    // Three writes then three reads
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, abc[i]);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      @(negedge write_clk);
      chk("abc_data", 32'(data_out), 32'(abc[i]));
      chk("abc_valid", 32'(valid), 32'd1);
    end
    chk("abc_empty", 32'(empty), 32'd1);

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
    @(negedge write_clk);
    chk("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 8'hFF);
    @(negedge write_clk);
    chk("fill_ovf", 32'(over_flow), 32'd1);
    cycle(1'b0, 1'b0, '0);
    @(negedge write_clk);
    chk("fill_ovf_once", 32'(over_flow), 32'd0);

    // Write+read while full: oldest out, write dropped, count 15
    cycle(1'b1, 1'b1, 8'hEE);
    @(negedge write_clk);
    chk("fullrw_data", 32'(data_out), 32'h00);
    chk("fullrw_ovf", 32'(over_flow), 32'd1);
    chk("fullrw_notfull", 32'(full), 32'd0);

    // Drain the rest: 0x01..0x0F
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      @(negedge write_clk);
      chk("drain_data", 32'(data_out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Read while empty: under_flow each cycle, data held
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      @(negedge write_clk);
      chk("udf_pulse", 32'(under_flow), 32'd1);
      chk("udf_valid", 32'(valid), 32'd0);
      chk("udf_hold", 32'(data_out), 32'h0F);
    end

    // Write+read while empty: write wins, read rejected
    cycle(1'b1, 1'b1, 8'h5A);
    @(negedge write_clk);
    chk("emptyrw_udf", 32'(under_flow), 32'd1);
    chk("emptyrw_valid", 32'(valid), 32'd0);
    chk("emptyrw_notempty", 32'(empty), 32'd0);
    cycle(1'b0, 1'b1, '0);
    @(negedge write_clk);
    chk("emptyrw_data", 32'(data_out), 32'h5A);

    // Random traffic across several pointer wraps
    for (int i = 0; i < 50; i++)
      cycle(1'b1, 1'($urandom_range(0, 2) != 0), 8'($urandom));
    for (int i = 0; i < 40 && m_q.size() != 0; i++) cycle(1'b0, 1'b1, '0);
    @(negedge write_clk);
    chk("rand_drained", 32'(m_q.size()), 32'd0);

    // Mid-operation reset with five entries stored
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h11 + i));
    @(negedge write_clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_data", 32'(data_out), 32'd0);
    @(negedge write_clk); #2 reset = 1'b1;
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, '0);
    @(negedge write_clk);
    chk("mrst_read", 32'(data_out), 32'h3C);
    chk("mrst_valid", 32'(valid), 32'd1);

    cycle(1'b0, 1'b0, '0);
    @(negedge write_clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
